// File: rtl/lmb_bram_pkg.sv
// Shared definitions for the dual-port LMB block RAM: controller state encoding
// and an elaboration-time ceil(log2()) helper.
package lmb_bram_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_CLEAR = 2'd1,
        S_READY = 2'd2
    } bram_state_e;

    function automatic int clog2(input int value);
        int res;
        int acc;
        res = 0;
        acc = 1;
        while (acc < value) begin
            acc = acc * 2;
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lmb_bram_dp_mem_if.sv
// Two-port LMB BRAM bus. Vectors keep the big-endian [0:N-1] numbering of the
// LMB bus: bit 0 is the MSB, WEN bit 0 enables byte [0:7].
interface lmb_bram_dp_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NUM_WE = DATA_W / 8
);
    logic              BRAM_EN_A;
    logic              BRAM_EN_B;
    logic [0:NUM_WE-1] BRAM_WEN_A;
    logic [0:NUM_WE-1] BRAM_WEN_B;
    logic [0:ADDR_W-1] BRAM_Addr_A;
    logic [0:ADDR_W-1] BRAM_Addr_B;
    logic [0:DATA_W-1] BRAM_Dout_A;
    logic [0:DATA_W-1] BRAM_Dout_B;
    logic [0:DATA_W-1] BRAM_Din_A;
    logic [0:DATA_W-1] BRAM_Din_B;
    logic              BRAM_Ready;
    logic              BRAM_Collision;
    logic              BRAM_Parity_Err_A;
    logic              BRAM_Parity_Err_B;

    modport master (
        output BRAM_EN_A, BRAM_EN_B, BRAM_WEN_A, BRAM_WEN_B,
               BRAM_Addr_A, BRAM_Addr_B, BRAM_Dout_A, BRAM_Dout_B,
        input  BRAM_Din_A, BRAM_Din_B, BRAM_Ready, BRAM_Collision,
               BRAM_Parity_Err_A, BRAM_Parity_Err_B
    );

    modport slave (
        input  BRAM_EN_A, BRAM_EN_B, BRAM_WEN_A, BRAM_WEN_B,
               BRAM_Addr_A, BRAM_Addr_B, BRAM_Dout_A, BRAM_Dout_B,
        output BRAM_Din_A, BRAM_Din_B, BRAM_Ready, BRAM_Collision,
               BRAM_Parity_Err_A, BRAM_Parity_Err_B
    );
endinterface

// File: rtl/lmb_bram_port.sv
// One BRAM access port: word-index decode, byte-lane write mask, read pipeline
// (1 or 2 stages) and, with LMB_BRAM_PARITY_EN, per-byte parity generate/check.
module lmb_bram_port
    import lmb_bram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_WE  = 4,
    parameter int IDX_W   = 14,
    parameter int LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [0:NUM_WE-1] wen_i,
    input  logic [0:ADDR_W-1] addr_i,
    input  logic [0:DATA_W-1] wdat_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic [IDX_W-1:0]  widx_o,
    output logic [DATA_W-1:0] wmask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic [0:DATA_W-1] din_o,
`ifdef LMB_BRAM_PARITY_EN
    input  logic [NUM_WE-1:0] rd_par_i,
    output logic [NUM_WE-1:0] wpar_o,
`endif
    output logic              perr_o
);
    localparam int OFS_W = clog2(NUM_WE);

    // Little-endian copies: numeric value is unchanged, WEN bit 0 lands on the top byte.
    logic [ADDR_W-1:0] addr_le;
    logic [NUM_WE-1:0] wen_le;
    logic              unused_addr;
    logic              perr_raw;
    logic [DATA_W-1:0] din_q;
    logic              perr_q;

    assign addr_le     = addr_i;
    assign wen_le      = wen_i;
    assign unused_addr = ^addr_le;
    assign widx_o      = addr_le[OFS_W +: IDX_W];
    assign we_o        = en_i & (|wen_le);
    assign wdata_o     = wdat_i;

    always_comb begin
        wmask_o = '0;
        for (int j = 0; j < NUM_WE; j++) begin
            wmask_o[8*j +: 8] = {8{en_i & wen_le[j]}};
        end
    end

`ifdef LMB_BRAM_PARITY_EN
    function automatic logic [NUM_WE-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NUM_WE-1:0] p;
        for (int j = 0; j < NUM_WE; j++) p[j] = ^w[8*j +: 8];
        return p;
    endfunction

    assign wpar_o   = byte_par(wdata_o);
    assign perr_raw = |(rd_par_i ^ byte_par(rd_word_i));
`else
    assign perr_raw = 1'b0;
`endif

    if (LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] rd_p1_q;
        logic              perr_p1_q;
        logic              vld_p1_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_p1_q   <= '0;
                perr_p1_q <= 1'b0;
                vld_p1_q  <= 1'b0;
                din_q     <= '0;
                perr_q    <= 1'b0;
            end else begin
                vld_p1_q <= en_i;
                if (en_i) begin
                    rd_p1_q   <= rd_word_i;
                    perr_p1_q <= perr_raw;
                end
                // Output stage: Din holds between reads, the error flag only pulses.
                perr_q <= vld_p1_q & perr_p1_q;
                if (vld_p1_q) din_q <= rd_p1_q;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                din_q  <= '0;
                perr_q <= 1'b0;
            end else begin
                perr_q <= en_i & perr_raw;
                if (en_i) din_q <= rd_word_i;
            end
        end
    end

    assign din_o  = din_q;
    assign perr_o = perr_q;

endmodule

// File: rtl/lmb_bram_dp_mem.sv
// Dual-port read-first LMB block RAM with post-reset zero-fill controller.
// Optional per-byte even parity when the macro LMB_BRAM_PARITY_EN is defined.
module lmb_bram_dp_mem
    import lmb_bram_pkg::*;
#(
    parameter int    C_MEMSIZE        = 'h10000,
    parameter int    C_PORT_DWIDTH    = 32,
    parameter int    C_PORT_AWIDTH    = 32,
    parameter int    C_NUM_WE         = C_PORT_DWIDTH / 8,
    parameter int    C_READ_LATENCY   = 1,
    parameter int    C_CLEAR_ON_RESET = 1,
    parameter string C_FAMILY         = "virtex4"
) (
    input logic               BRAM_Clk,
    input logic               BRAM_Rst_N,
    lmb_bram_dp_mem_if.slave  bus
);
    localparam int DW    = C_PORT_DWIDTH;
    localparam int NW    = C_NUM_WE;
    localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
    localparam int IDX_W = clog2(DEPTH);

    if ((C_READ_LATENCY != 1 && C_READ_LATENCY != 2) || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0 ||
        (C_PORT_DWIDTH % 8) != 0 || IDX_W < 1 || C_FAMILY == "") begin : g_param_check
        $error("lmb_bram_dp_mem: unsupported parameter combination");
    end

    bram_state_e      state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             ready_q;
    logic             coll_q;

    logic             acc_a, acc_b, we_a, we_b;
    logic [IDX_W-1:0] widx_a, widx_b;
    logic [DW-1:0]    wmask_a, wmask_b, wdata_a, wdata_b, mask_bx;
    logic [DW-1:0]    wr_a_word, wr_b_word;
    logic [DW-1:0]    mem_q [DEPTH];

    assign acc_a = bus.BRAM_EN_A & (state_q == S_READY);
    assign acc_b = bus.BRAM_EN_B & (state_q == S_READY);

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            state_q   <= S_RESET;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            coll_q <= acc_a & acc_b & (widx_a == widx_b) & (we_a | we_b);
            case (state_q)
                S_RESET: begin
                    if (C_CLEAR_ON_RESET != 0) begin
                        state_q <= S_CLEAR;
                    end else begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Same-word double write: A's update carries B's non-overlapping bytes so A wins per byte.
    assign mask_bx   = (widx_a == widx_b) ? wmask_b : '0;
    assign wr_b_word = (mem_q[widx_b] & ~wmask_b) | (wdata_b & wmask_b);
    assign wr_a_word = (mem_q[widx_a] & ~(wmask_a | mask_bx)) |
                       (wdata_b & mask_bx & ~wmask_a) | (wdata_a & wmask_a);

    always_ff @(posedge BRAM_Clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (we_b) mem_q[widx_b] <= wr_b_word;
            if (we_a) mem_q[widx_a] <= wr_a_word;
        end
    end

`ifdef LMB_BRAM_PARITY_EN
    logic [NW-1:0] par_q [DEPTH];
    logic [NW-1:0] wpar_a, wpar_b, pen_a, pen_b, pen_bx;

    always_comb begin
        pen_a = '0;
        pen_b = '0;
        for (int j = 0; j < NW; j++) begin
            pen_a[j] = wmask_a[8*j];
            pen_b[j] = wmask_b[8*j];
        end
        pen_bx = (widx_a == widx_b) ? pen_b : '0;
    end

    // Zero bytes have even parity 0, so the clear also leaves valid parity behind.
    always_ff @(posedge BRAM_Clk) begin
        if (state_q == S_CLEAR) begin
            par_q[clr_cnt_q] <= '0;
        end else begin
            if (we_b) par_q[widx_b] <= (par_q[widx_b] & ~pen_b) | (wpar_b & pen_b);
            if (we_a) par_q[widx_a] <= (par_q[widx_a] & ~(pen_a | pen_bx)) |
                                       (wpar_b & pen_bx & ~pen_a) | (wpar_a & pen_a);
        end
    end
`endif

    lmb_bram_port #(
        .DATA_W(DW), .ADDR_W(C_PORT_AWIDTH), .NUM_WE(NW), .IDX_W(IDX_W), .LATENCY(C_READ_LATENCY)
    ) u_port_a (
        .clk_i(BRAM_Clk), .rst_ni(BRAM_Rst_N), .en_i(acc_a), .wen_i(bus.BRAM_WEN_A),
        .addr_i(bus.BRAM_Addr_A), .wdat_i(bus.BRAM_Dout_A), .rd_word_i(mem_q[widx_a]),
        .widx_o(widx_a), .wmask_o(wmask_a), .wdata_o(wdata_a), .we_o(we_a),
        .din_o(bus.BRAM_Din_A),
`ifdef LMB_BRAM_PARITY_EN
        .rd_par_i(par_q[widx_a]), .wpar_o(wpar_a),
`endif
        .perr_o(bus.BRAM_Parity_Err_A)
    );

    lmb_bram_port #(
        .DATA_W(DW), .ADDR_W(C_PORT_AWIDTH), .NUM_WE(NW), .IDX_W(IDX_W), .LATENCY(C_READ_LATENCY)
    ) u_port_b (
        .clk_i(BRAM_Clk), .rst_ni(BRAM_Rst_N), .en_i(acc_b), .wen_i(bus.BRAM_WEN_B),
        .addr_i(bus.BRAM_Addr_B), .wdat_i(bus.BRAM_Dout_B), .rd_word_i(mem_q[widx_b]),
        .widx_o(widx_b), .wmask_o(wmask_b), .wdata_o(wdata_b), .we_o(we_b),
        .din_o(bus.BRAM_Din_B),
`ifdef LMB_BRAM_PARITY_EN
        .rd_par_i(par_q[widx_b]), .wpar_o(wpar_b),
`endif
        .perr_o(bus.BRAM_Parity_Err_B)
    );

    assign bus.BRAM_Ready     = ready_q;
    assign bus.BRAM_Collision = coll_q;

endmodule

// File: doc/lmb_bram_dp_mem.md
LMB_BRAM_DP_MEM -- requirements
Module: lmb_bram_dp_mem

Interface
REQ-001 SHALL have parameter C_MEMSIZE, default 'h10000, size in bytes (power of two).
REQ-002 SHALL have parameter C_PORT_DWIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter C_PORT_AWIDTH, default 32, byte-address width.
REQ-004 SHALL have parameter C_NUM_WE, default C_PORT_DWIDTH/8, byte enables per port.
REQ-005 SHALL have parameter C_READ_LATENCY, default 1, read latency (legal values 1 or 2).
REQ-006 SHALL have parameter C_CLEAR_ON_RESET, default 1, zero-fill after reset.
REQ-007 SHALL have parameter C_FAMILY, default "virtex4", target family string.
REQ-008 BRAM_Clk  in  1  single clock for both ports; all logic on its rising edge.
REQ-009 BRAM_Rst_N  in  1  reset; asynchronous, active-low.
REQ-010 BRAM_EN_A / BRAM_EN_B  in  1  port access enable.
REQ-011 BRAM_WEN_A / BRAM_WEN_B  in  [0:C_NUM_WE-1]  byte write enables; bit 0 = byte [0:7].
REQ-012 BRAM_Addr_A / BRAM_Addr_B  in  [0:C_PORT_AWIDTH-1]  byte address, bit C_PORT_AWIDTH-1 = LSB.
REQ-013 BRAM_Dout_A / BRAM_Dout_B  in  [0:C_PORT_DWIDTH-1]  write data from master.
REQ-014 BRAM_Din_A / BRAM_Din_B  out  [0:C_PORT_DWIDTH-1]  read data to master.
REQ-015 BRAM_Ready  out  1  memory accepts accesses.
REQ-016 BRAM_Collision  out  1  same-word cross-port conflict flag.
REQ-017 BRAM_Parity_Err_A / BRAM_Parity_Err_B  out  1  read parity error, aligned with Din.

Function
REQ-018 Depth SHALL be C_MEMSIZE/C_NUM_WE words; word index = address LSBs above the log2(C_NUM_WE) byte-offset bits; higher bits ignored (aliasing wraps).
REQ-019 Enabled access with any WEN bit set SHALL write only the enabled bytes; disabled bytes unchanged.
REQ-020 Every enabled access SHALL return the pre-write (read-first) word on Din after exactly C_READ_LATENCY cycles; Din SHALL hold its value when EN is low.
REQ-021 C_READ_LATENCY=2 SHALL add one output register stage after the array read.
REQ-022 Both ports writing the same word in the same cycle SHALL resolve per byte: port A wins overlapping bytes, port B's non-overlapping bytes written.
REQ-023 BRAM_Collision SHALL pulse one cycle, registered, the cycle after both ports are enabled on the same word with at least one writing.
REQ-024 State machine: S_RESET -> S_CLEAR (C_CLEAR_ON_RESET=1) or S_READY (=0) on first clock after reset release; S_CLEAR -> S_READY after last word written.
REQ-025 In S_CLEAR SHALL write zero to words 0..depth-1, one per cycle, via an internal counter; BRAM_Ready=0; port accesses ignored (no write, Din unchanged).
REQ-026 BRAM_Ready SHALL be 1 only in S_READY.

Reset
REQ-027 Reset assertion SHALL asynchronously force S_RESET, clear counter, Din_A/Din_B=0, BRAM_Ready=0, BRAM_Collision=0, Parity_Err_A/B=0, and flush the latency pipeline.
REQ-028 Reset during S_CLEAR SHALL restart the clear from word 0; array contents are not otherwise reset.

Configuration
REQ-029 Macro LMB_BRAM_PARITY_EN defined: SHALL store one even-parity bit per byte on write, check on read, and assert Parity_Err_x one cycle aligned with the erroneous Din; clear writes valid parity.
REQ-030 Macro undefined: SHALL store no parity bits; Parity_Err_A/B tied 0.

Structure
REQ-031 Shared package lmb_bram_pkg SHALL hold the state-encoding typedef (S_RESET, S_CLEAR, S_READY) and a clog2 constant function.
REQ-032 One sub-module lmb_bram_port SHALL implement per-port address decode, read pipeline and parity check, instantiated twice.

Verification
REQ-033 Defaults, C_CLEAR_ON_RESET=1: release reset -> Ready rises after 16384 clear cycles; read word 'h3FFC -> Din 0.
REQ-034 Port A write 'h12345678 WEN 1111 at 'h0010, then port B read 'h0010 -> Din_B 'h12345678 one cycle after read.
REQ-035 Write WEN 0100 data 'hAABBCCDD over 'h11111111 -> read 'h11BB1111.
REQ-036 Same cycle A WEN 1100 'hAAAAAAAA, B WEN 0110 'hBBBBBBBB, same word -> word 'hAAAABB00 (from zero), Collision pulses once.
REQ-037 Address 'h0001_0004 with C_MEMSIZE 'h10000 -> accesses word 1; C_READ_LATENCY=2 -> Din valid 2 cycles after EN.
REQ-038 Reset asserted mid-clear at word 100 -> Ready 0, clear restarts at word 0; with LMB_BRAM_PARITY_EN, forced stored-parity flip -> Parity_Err pulses with that read.
